// File: rtl/rk86_bus_pkg.sv
// Shared definitions for the RK86 bus arbiter: FSM state encoding, the idle
// strobe pattern and the bus owner codes.
package rk86_bus_pkg;

    typedef enum logic [2:0] {
        ST_CPU      = 3'd0,
        ST_REQ      = 3'd1,
        ST_TURN_IN  = 3'd2,
        ST_DMA      = 3'd3,
        ST_TURN_OUT = 3'd4,
        ST_COOL     = 3'd5
    } arb_state_e;

    // Strobe order everywhere: {rd_n, wr_n, iord_n, iowr_n}.
    localparam logic [3:0] STROBE_IDLE = 4'b1111;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Handover guard states drive all strobes inactive.
    function automatic logic is_guard(arb_state_e s);
        return (s == ST_TURN_IN) || (s == ST_TURN_OUT);
    endfunction

endpackage

// File: rtl/rk86_bus_arb_cnt.sv
// Clock-enabled loadable saturating up/down counter.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (clears to 0)
//   ce_i           clock enable; nothing changes while low
//   load_i         load load_val_i (highest priority)
//   up_i / down_i  count up (saturates at MaxVal) / down (saturates at 0)
//   cnt_o          current count
module rk86_bus_arb_cnt #(
    parameter int unsigned Width  = 4,
    parameter int unsigned MaxVal = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             up_i,
    input  logic             down_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [Width-1:0] CntMax = Width'(MaxVal);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (up_i) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + Width'(1);
        end else if (down_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (ce_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rk86_bus_arbiter.sv
// Bus arbiter between the 8080 CPU and the K580WT57 DMA controller.
// DMA hrq is turned into CPU HOLD; once the CPU answers with HLDA the DMA is
// granted (dma_hlda_o). Every handover passes through a guard cycle with all
// strobes idle, and after each DMA tenure the CPU keeps the bus for
// MIN_CPU_SLOT ce cycles before a new request is honoured. A watchdog flags
// DMA tenures of MAX_HOLD ce cycles or more; proto_err_o flags the CPU
// dropping HLDA while the DMA owns the bus. Both flags are sticky until
// err_clr_i.
// Ports:
//   clk_i, reset_i, ce_i        clock, async active-high reset, clock enable
//   err_clr_i                   clears bus_timeout_o / proto_err_o
//   dma_hrq_i, dma_hlda_o       DMA request / registered grant
//   cpu_hold_o, cpu_hlda_i      registered CPU HOLD / CPU acknowledge
//   cpu_*_i, dma_*_i            address and active-low strobes of each master
//   bus_*_o                     muxed address and strobes
//   bus_owner_o                 0 = CPU, 1 = DMA
//   bus_timeout_o, proto_err_o  sticky error flags
module rk86_bus_arbiter
    import rk86_bus_pkg::*;
#(
    parameter int unsigned MIN_CPU_SLOT = 4,
    parameter int unsigned MAX_HOLD     = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ce_i,
    input  logic        err_clr_i,
    input  logic        dma_hrq_i,
    output logic        dma_hlda_o,
    output logic        cpu_hold_o,
    input  logic        cpu_hlda_i,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_rd_n_i,
    input  logic        cpu_wr_n_i,
    input  logic        cpu_iord_n_i,
    input  logic        cpu_iowr_n_i,
    input  logic [15:0] dma_addr_i,
    input  logic        dma_rd_n_i,
    input  logic        dma_we_n_i,
    input  logic        dma_iord_n_i,
    input  logic        dma_iowe_n_i,
    output logic [15:0] bus_addr_o,
    output logic        bus_rd_n_o,
    output logic        bus_wr_n_o,
    output logic        bus_iord_n_o,
    output logic        bus_iowr_n_o,
    output logic        bus_owner_o,
    output logic        bus_timeout_o,
    output logic        proto_err_o
);

    localparam int unsigned SlotW = (MIN_CPU_SLOT > 0) ? $clog2(MIN_CPU_SLOT + 1) : 1;
    localparam int unsigned WdW   = $clog2(MAX_HOLD + 1);

    localparam logic [SlotW-1:0] SlotInit = SlotW'(MIN_CPU_SLOT);
    localparam logic [SlotW-1:0] SlotOne  = SlotW'(1);
    localparam logic [WdW-1:0]   WdLast   = WdW'(MAX_HOLD - 1);

    arb_state_e state_q, state_d;
    logic       dma_hlda_q, dma_hlda_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       timeout_q, timeout_d;
    logic       proto_err_q, proto_err_d;

    logic             slot_load, slot_dec;
    logic             wd_clr, wd_inc;
    logic             timeout_set, proto_set;
    logic [SlotW-1:0] slot_q;
    logic [WdW-1:0]   wd_q;

    rk86_bus_arb_cnt #(
        .Width  (SlotW),
        .MaxVal (MIN_CPU_SLOT)
    ) u_slot_cnt (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .ce_i       (ce_i),
        .load_i     (slot_load),
        .load_val_i (SlotInit),
        .up_i       (1'b0),
        .down_i     (slot_dec),
        .cnt_o      (slot_q)
    );

    rk86_bus_arb_cnt #(
        .Width  (WdW),
        .MaxVal (MAX_HOLD)
    ) u_watchdog (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .ce_i       (ce_i),
        .load_i     (wd_clr),
        .load_val_i ('0),
        .up_i       (wd_inc),
        .down_i     (1'b0),
        .cnt_o      (wd_q)
    );

    always_comb begin
        state_d     = state_q;
        slot_load   = 1'b0;
        slot_dec    = 1'b0;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        timeout_set = 1'b0;
        proto_set   = 1'b0;

        unique case (state_q)
            ST_CPU: begin
                if (dma_hrq_i) state_d = ST_REQ;
            end
            ST_REQ: begin
                // A withdrawn request beats a simultaneous HLDA.
                if (!dma_hrq_i) begin
                    state_d = ST_CPU;
                end else if (cpu_hlda_i) begin
                    state_d = ST_TURN_IN;
                end
            end
            ST_TURN_IN: begin
                state_d = ST_DMA;
                wd_clr  = 1'b1;
            end
            ST_DMA: begin
                wd_inc = 1'b1;
                // Fires only on the step that reaches MAX_HOLD; the count then
                // saturates, so a cleared flag stays cleared for this tenure.
                if (wd_q == WdLast) timeout_set = 1'b1;
                if (!cpu_hlda_i) begin
                    proto_set = 1'b1;
                    state_d   = ST_TURN_OUT;
                end else if (!dma_hrq_i) begin
                    state_d = ST_TURN_OUT;
                end
            end
            ST_TURN_OUT: begin
                if (MIN_CPU_SLOT == 0) begin
                    state_d = ST_CPU;
                end else begin
                    state_d   = ST_COOL;
                    slot_load = 1'b1;
                end
            end
            ST_COOL: begin
                // Leave on the step that brings the slot count to zero, so the
                // CPU gets exactly MIN_CPU_SLOT cycles here.
                slot_dec = 1'b1;
                if (slot_q <= SlotOne) state_d = ST_CPU;
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase

        cpu_hold_d  = (state_d == ST_REQ) || (state_d == ST_TURN_IN) || (state_d == ST_DMA);
        dma_hlda_d  = (state_d == ST_DMA);
        timeout_d   = timeout_set | (timeout_q & ~err_clr_i);
        proto_err_d = proto_set | (proto_err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_CPU;
            dma_hlda_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else if (ce_i) begin
            state_q     <= state_d;
            dma_hlda_q  <= dma_hlda_d;
            cpu_hold_q  <= cpu_hold_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Output mux: combinational from the registered state, live data inputs.
    logic owner;
    logic [3:0] strobes;

    always_comb begin
        owner = ((state_q == ST_TURN_IN) || (state_q == ST_DMA)) ? OWN_DMA : OWN_CPU;
        if (is_guard(state_q)) begin
            strobes = STROBE_IDLE;
        end else if (owner == OWN_DMA) begin
            strobes = {dma_rd_n_i, dma_we_n_i, dma_iord_n_i, dma_iowe_n_i};
        end else begin
            strobes = {cpu_rd_n_i, cpu_wr_n_i, cpu_iord_n_i, cpu_iowr_n_i};
        end
    end

    assign bus_addr_o    = (owner == OWN_DMA) ? dma_addr_i : cpu_addr_i;
    assign bus_rd_n_o    = strobes[3];
    assign bus_wr_n_o    = strobes[2];
    assign bus_iord_n_o  = strobes[1];
    assign bus_iowr_n_o  = strobes[0];
    assign bus_owner_o   = owner;
    assign dma_hlda_o    = dma_hlda_q;
    assign cpu_hold_o    = cpu_hold_q;
    assign bus_timeout_o = timeout_q;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_rk86_bus_arbiter.sv
// Self-checking bench for rk86_bus_arbiter. Each scenario pushes the expected
// observable state for a ce step into a scoreboard queue as it drives the
// stimulus, then pops and compares once the step has been clocked.
// Observed vector: {dma_hlda, cpu_hold, bus_owner, bus_timeout, proto_err,
//                   bus_addr[15:0], rd_n, wr_n, iord_n, iowr_n}.
module tb_rk86_bus_arbiter;

    localparam logic [15:0] CPU_A  = 16'h1234;
    localparam logic [15:0] DMA_A  = 16'h76D0;
    localparam logic [3:0]  CPU_S  = 4'b1011;  // CPU memory write
    localparam logic [3:0]  DMA_S  = 4'b0111;  // DMA memory read
    localparam logic [3:0]  IDLE_S = 4'b1111;

    logic        clk, reset, ce, err_clr;
    logic        dma_hrq, dma_hlda, cpu_hold, cpu_hlda;
    logic [15:0] cpu_addr, dma_addr, bus_addr;
    logic        cpu_rd_n, cpu_wr_n, cpu_iord_n, cpu_iowr_n;
    logic        dma_rd_n, dma_we_n, dma_iord_n, dma_iowe_n;
    logic        bus_rd_n, bus_wr_n, bus_iord_n, bus_iowr_n;
    logic        bus_owner, bus_timeout, proto_err;

    typedef struct {
        string       name;
        logic [24:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ce_gap = 0;

    rk86_bus_arbiter #(
        .MIN_CPU_SLOT (4),
        .MAX_HOLD     (1024)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ce_i          (ce),
        .err_clr_i     (err_clr),
        .dma_hrq_i     (dma_hrq),
        .dma_hlda_o    (dma_hlda),
        .cpu_hold_o    (cpu_hold),
        .cpu_hlda_i    (cpu_hlda),
        .cpu_addr_i    (cpu_addr),
        .cpu_rd_n_i    (cpu_rd_n),
        .cpu_wr_n_i    (cpu_wr_n),
        .cpu_iord_n_i  (cpu_iord_n),
        .cpu_iowr_n_i  (cpu_iowr_n),
        .dma_addr_i    (dma_addr),
        .dma_rd_n_i    (dma_rd_n),
        .dma_we_n_i    (dma_we_n),
        .dma_iord_n_i  (dma_iord_n),
        .dma_iowe_n_i  (dma_iowe_n),
        .bus_addr_o    (bus_addr),
        .bus_rd_n_o    (bus_rd_n),
        .bus_wr_n_o    (bus_wr_n),
        .bus_iord_n_o  (bus_iord_n),
        .bus_iowr_n_o  (bus_iowr_n),
        .bus_owner_o   (bus_owner),
        .bus_timeout_o (bus_timeout),
        .proto_err_o   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] ev(logic hl, logic ho, logic ow, logic tm, logic pe,
                                       logic [15:0] a, logic [3:0] s);
        return {hl, ho, ow, tm, pe, a, s};
    endfunction

    function automatic logic [24:0] sample();
        return {dma_hlda, cpu_hold, bus_owner, bus_timeout, proto_err, bus_addr,
                bus_rd_n, bus_wr_n, bus_iord_n, bus_iowr_n};
    endfunction

    // One ce step: ce_gap disabled clocks, then one enabled edge, sample at +1.
    task automatic step();
        repeat (ce_gap) begin
            ce = 1'b0;
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic hrq, logic hlda, logic clr);
        dma_hrq  = hrq;
        cpu_hlda = hlda;
        err_clr  = clr;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [24:0] got;
        // Power-on reset is held from time 0.
        repeat (3) @(posedge clk);
        #1;
        e.name = "reset_por"; e.v = ev(0, 0, 0, 0, 0, CPU_A, CPU_S); sb.push_back(e);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, got, e.v);
        end
        reset = 1'b0;
        // Walk into ST_DMA, then pulse reset between clock edges.
        drive(1, 0, 0); step();
        drive(1, 1, 0); step();
        step();
        #2;
        reset = 1'b1;
        #1;
        e.name = "reset_mid_dma"; e.v = ev(0, 0, 0, 0, 0, CPU_A, CPU_S); sb.push_back(e);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, got, e.v);
        end
        drive(0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // From ST_CPU idle, ends in ST_DMA with hrq=hlda=1.
    task automatic test_handover(string tag);
        exp_t        e;
        logic [24:0] got;
        logic [1:0]  st [4];
        logic [24:0] ex [4];
        st = '{2'b10, 2'b10, 2'b11, 2'b11};
        ex = '{ev(0, 1, 0, 0, 0, CPU_A, CPU_S),    // ST_REQ, HOLD up
               ev(0, 1, 0, 0, 0, CPU_A, CPU_S),    // still waiting for HLDA
               ev(0, 1, 1, 0, 0, DMA_A, IDLE_S),   // guard despite dma_rd_n=0
               ev(1, 1, 1, 0, 0, DMA_A, DMA_S)};   // granted
        for (int i = 0; i < 4; i++) begin
            drive(st[i][1], st[i][0], 0);
            e.name = tag; e.v = ex[i]; sb.push_back(e);
            step();
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i, got, e.v);
            end
        end
    endtask

    // From ST_DMA: release, immediate re-request, cooldown, new grant.
    task automatic test_release();
        exp_t        e;
        logic [24:0] got;
        logic [1:0]  st [9];
        logic [24:0] ex [9];
        st = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        ex = '{ev(0, 0, 0, 0, 0, CPU_A, IDLE_S),   // guard out
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S),    // slot cycle 1 (hrq ignored)
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S),    // slot cycle 2
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S),    // slot cycle 3
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S),    // slot cycle 4
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S),    // ST_CPU samples the request
               ev(0, 1, 0, 0, 0, CPU_A, CPU_S),    // HOLD re-asserted
               ev(0, 1, 1, 0, 0, DMA_A, IDLE_S),
               ev(1, 1, 1, 0, 0, DMA_A, DMA_S)};
        for (int i = 0; i < 9; i++) begin
            drive(st[i][1], st[i][0], 0);
            e.name = "release_slot"; e.v = ex[i]; sb.push_back(e);
            step();
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i, got, e.v);
            end
        end
    endtask

    // Entered right after ST_DMA entry (watchdog = 0). Ends in ST_CPU idle.
    task automatic test_watchdog();
        exp_t        e;
        logic [24:0] got;
        logic [2:0]  st [5];
        logic [24:0] ex [5];
        drive(1, 1, 0);
        repeat (1022) step();
        st = '{3'b110, 3'b110, 3'b111, 3'b100, 3'b101};  // {hrq, hlda, err_clr}
        ex = '{ev(1, 1, 1, 0, 0, DMA_A, DMA_S),    // 1023 cycles: not yet
               ev(1, 1, 1, 1, 0, DMA_A, DMA_S),    // 1024: flag, grant kept
               ev(1, 1, 1, 0, 0, DMA_A, DMA_S),    // err_clr clears it
               ev(0, 0, 0, 0, 1, CPU_A, IDLE_S),   // HLDA lost: proto_err
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S)};   // err_clr clears it
        for (int i = 0; i < 5; i++) begin
            drive(st[i][2], st[i][1], st[i][0]);
            e.name = "watchdog_proto"; e.v = ex[i]; sb.push_back(e);
            step();
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i, got, e.v);
            end
        end
        drive(0, 0, 0);
        repeat (8) step();
    endtask

    task automatic test_withdraw();
        exp_t        e;
        logic [24:0] got;
        logic [1:0]  st [3];
        logic [24:0] ex [3];
        st = '{2'b10, 2'b01, 2'b01};
        ex = '{ev(0, 1, 0, 0, 0, CPU_A, CPU_S),
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S),    // withdrawal beats HLDA
               ev(0, 0, 0, 0, 0, CPU_A, CPU_S)};
        for (int i = 0; i < 3; i++) begin
            drive(st[i][1], st[i][0], 0);
            e.name = "withdraw"; e.v = ex[i]; sb.push_back(e);
            step();
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i, got, e.v);
            end
        end
        drive(0, 0, 0);
        step();
    endtask

    task automatic test_ce_gating();
        exp_t        e;
        logic [24:0] got;
        ce_gap = 2;
        test_handover("handover_ce_1of3");
        // With ce low, a dropped request must not move the FSM, while the mux
        // still follows a changing DMA address.
        ce = 1'b0;
        dma_hrq = 1'b0;
        dma_addr = 16'hBEEF;
        e.name = "ce_hold"; e.v = ev(1, 1, 1, 0, 0, 16'hBEEF, DMA_S); sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, got, e.v);
        end
        dma_addr = DMA_A;
        ce_gap = 0;
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b1;
        err_clr = 1'b0;
        dma_hrq = 1'b0;
        cpu_hlda = 1'b0;
        cpu_addr = CPU_A;
        {cpu_rd_n, cpu_wr_n, cpu_iord_n, cpu_iowr_n} = CPU_S;
        dma_addr = DMA_A;
        {dma_rd_n, dma_we_n, dma_iord_n, dma_iowe_n} = DMA_S;

        test_reset();
        test_handover("handover");
        test_release();
        test_watchdog();
        test_withdraw();
        test_ce_gating();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
